// File: rtl/spi_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : spi_arbiter
// Brief    : Two-client round-robin arbiter and transfer sequencer in front of
//            a 16-bit SPI master (start, busy tracking, timeouts, CS guard gap).
// Revision : 1.0 - initial release
// ============================================================================
module spi_arbiter #(
    parameter int unsigned GUARD_CYCLES = 4,
    parameter int unsigned START_WAIT   = 3,
    parameter logic [23:0] TIMEOUT      = 24'h400000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0_i,
    input  logic        req1_i,
    input  logic [15:0] wdata0_i,
    input  logic [15:0] wdata1_i,
    input  logic [15:0] div0_i,
    input  logic [15:0] div1_i,
    output logic        done0_o,
    output logic        done1_o,
    output logic        err0_o,
    output logic        err1_o,
    output logic [15:0] rdata0_o,
    output logic [15:0] rdata1_o,
    output logic        spi_start_o,
    output logic [15:0] spi_data_o,
    output logic [15:0] spi_div_o,
    input  logic        spi_busy_i,
    input  logic [15:0] spi_rdata_i,
    output logic        owner_o,
    output logic        active_o
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_LAUNCH    = 3'd1,
        S_WAIT_BUSY = 3'd2,
        S_WAIT_DONE = 3'd3,
        S_RESP      = 3'd4,
        S_GUARD     = 3'd5,
        S_RECOVER   = 3'd6
    } state_t;

    state_t      state_q, state_d;
    logic        last_q, last_d;
    logic        owner_q, owner_d;
    logic        active_q, active_d;
    logic        spi_start_q, spi_start_d;
    logic [15:0] spi_data_q, spi_data_d;
    logic [15:0] spi_div_q, spi_div_d;
    logic        done0_q, done0_d;
    logic        done1_q, done1_d;
    logic        err0_q, err0_d;
    logic        err1_q, err1_d;
    logic [15:0] rdata0_q, rdata0_d;
    logic [15:0] rdata1_q, rdata1_d;
    logic [23:0] cnt_q, cnt_d;
    logic        recover_q, recover_d;
    logic        busy_q;

    logic        w_grant;
    logic [15:0] w_div_sel;
    logic        w_busy_fall;
    logic        w_start_expired;
    logic        w_guard_done;
    state_t      w_after_resp;
    logic        w_fin;
    logic        w_fin_err;

    // Both requesting: the client not served last wins; otherwise the lone requester.
    assign w_grant         = (req0_i && req1_i) ? ~last_q : req1_i;
    assign w_div_sel       = w_grant ? div1_i : div0_i;
    assign w_busy_fall     = busy_q && !spi_busy_i;
    assign w_start_expired = (32'(cnt_q) + 32'd1) >= START_WAIT;
    assign w_guard_done    = (32'(cnt_q) + 32'd1) >= GUARD_CYCLES;
    assign w_after_resp    = (GUARD_CYCLES == 0) ? S_IDLE : S_GUARD;

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        owner_d     = owner_q;
        active_d    = active_q;
        spi_start_d = 1'b0;
        spi_data_d  = spi_data_q;
        spi_div_d   = spi_div_q;
        done0_d     = 1'b0;
        done1_d     = 1'b0;
        err0_d      = 1'b0;
        err1_d      = 1'b0;
        rdata0_d    = rdata0_q;
        rdata1_d    = rdata1_q;
        cnt_d       = cnt_q;
        recover_d   = recover_q;
        w_fin       = 1'b0;
        w_fin_err   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (req0_i || req1_i) begin
                    owner_d    = w_grant;
                    last_d     = w_grant;
                    active_d   = 1'b1;
                    spi_data_d = w_grant ? wdata1_i : wdata0_i;
                    // The master underflows on a zero divider.
                    spi_div_d  = (w_div_sel == 16'd0) ? 16'd1 : w_div_sel;
                    state_d    = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                spi_start_d = 1'b1;
                cnt_d       = 24'd0;
                state_d     = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                if (spi_busy_i) begin
                    cnt_d   = 24'd0;
                    state_d = S_WAIT_DONE;
                end else if (w_start_expired) begin
                    w_fin     = 1'b1;
                    w_fin_err = 1'b1;
                end else begin
                    cnt_d = cnt_q + 24'd1;
                end
            end
            S_WAIT_DONE: begin
                if (w_busy_fall) begin
                    w_fin = 1'b1;
                    if (owner_q) begin
                        rdata1_d = spi_rdata_i;
                    end else begin
                        rdata0_d = spi_rdata_i;
                    end
                end else if (cnt_q == TIMEOUT) begin
                    w_fin     = 1'b1;
                    w_fin_err = 1'b1;
                    recover_d = 1'b1;
                end else if (cnt_q != 24'hFF_FFFF) begin
                    cnt_d = cnt_q + 24'd1;
                end
            end
            S_RESP: begin
                active_d = 1'b0;
                cnt_d    = 24'd0;
                state_d  = recover_q ? S_RECOVER : w_after_resp;
            end
            S_GUARD: begin
                if (w_guard_done) begin
                    cnt_d   = 24'd0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 24'd1;
                end
            end
            S_RECOVER: begin
                // A stuck master must finish before the guard gap may start.
                if (!spi_busy_i) begin
                    recover_d = 1'b0;
                    state_d   = w_after_resp;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (w_fin) begin
            state_d = S_RESP;
            done0_d = !owner_q;
            done1_d = owner_q;
            err0_d  = w_fin_err && !owner_q;
            err1_d  = w_fin_err && owner_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            last_q      <= 1'b1;
            owner_q     <= 1'b0;
            active_q    <= 1'b0;
            spi_start_q <= 1'b0;
            spi_data_q  <= 16'd0;
            spi_div_q   <= 16'd1;
            done0_q     <= 1'b0;
            done1_q     <= 1'b0;
            err0_q      <= 1'b0;
            err1_q      <= 1'b0;
            rdata0_q    <= 16'd0;
            rdata1_q    <= 16'd0;
            cnt_q       <= 24'd0;
            recover_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            owner_q     <= owner_d;
            active_q    <= active_d;
            spi_start_q <= spi_start_d;
            spi_data_q  <= spi_data_d;
            spi_div_q   <= spi_div_d;
            done0_q     <= done0_d;
            done1_q     <= done1_d;
            err0_q      <= err0_d;
            err1_q      <= err1_d;
            rdata0_q    <= rdata0_d;
            rdata1_q    <= rdata1_d;
            cnt_q       <= cnt_d;
            recover_q   <= recover_d;
            busy_q      <= spi_busy_i;
        end
    end

    assign done0_o     = done0_q;
    assign done1_o     = done1_q;
    assign err0_o      = err0_q;
    assign err1_o      = err1_q;
    assign rdata0_o    = rdata0_q;
    assign rdata1_o    = rdata1_q;
    assign spi_start_o = spi_start_q;
    assign spi_data_o  = spi_data_q;
    assign spi_div_o   = spi_div_q;
    assign owner_o     = owner_q;
    assign active_o    = active_q;

endmodule

`default_nettype wire

// File: tb/tb_spi_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_arbiter
// Brief    : Directed self-checking bench for spi_arbiter with a simple SPI
//            master model (loopback, never-busy and stuck-busy behaviours).
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_arbiter;

    localparam int          GUARD = 4;
    localparam int          SW    = 3;
    localparam logic [23:0] TO    = 24'd40;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req0 = 1'b0, req1 = 1'b0;
    logic [15:0] wdata0 = 16'd0, wdata1 = 16'd0, div0 = 16'd1, div1 = 16'd1;
    logic        done0, done1, err0, err1, spi_start, owner, active;
    logic [15:0] rdata0, rdata1, spi_data, spi_div;
    logic        spi_busy;
    logic [15:0] spi_rdata;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    spi_arbiter #(
        .GUARD_CYCLES(GUARD),
        .START_WAIT  (SW),
        .TIMEOUT     (TO)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req0_i     (req0),
        .req1_i     (req1),
        .wdata0_i   (wdata0),
        .wdata1_i   (wdata1),
        .div0_i     (div0),
        .div1_i     (div1),
        .done0_o    (done0),
        .done1_o    (done1),
        .err0_o     (err0),
        .err1_o     (err1),
        .rdata0_o   (rdata0),
        .rdata1_o   (rdata1),
        .spi_start_o(spi_start),
        .spi_data_o (spi_data),
        .spi_div_o  (spi_div),
        .spi_busy_i (spi_busy),
        .spi_rdata_i(spi_rdata),
        .owner_o    (owner),
        .active_o   (active)
    );

    // Master model: mode 0 loopback, busy 4*div cycles; mode 1 never busy; mode 2 busy 120 cycles.
    int          mode = 0;
    int          m_left;
    logic [15:0] m_data;
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            spi_busy  <= 1'b0;
            spi_rdata <= 16'd0;
            m_left    <= 0;
            m_data    <= 16'd0;
        end else if (spi_busy) begin
            if (m_left <= 1) begin
                spi_busy  <= 1'b0;
                spi_rdata <= m_data;
            end
            m_left <= m_left - 1;
        end else if (spi_start && mode != 1) begin
            spi_busy <= 1'b1;
            m_data   <= spi_data;
            m_left   <= (mode == 2) ? 120 : 4 * int'(spi_div);
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          n_start = 0, n_done0 = 0, n_done1 = 0, both_viol = 0, busy_start_viol = 0;
    int          fall_cyc = 0;
    logic        busy_prev = 1'b0;
    logic        own_log[$];
    logic [15:0] div_log[$];
    int          start_log[$];
    always @(negedge clk) begin
        if (spi_start) begin
            n_start <= n_start + 1;
            own_log.push_back(owner);
            div_log.push_back(spi_div);
            start_log.push_back(cyc);
            if (spi_busy) busy_start_viol <= busy_start_viol + 1;
        end
        if (done0) n_done0 <= n_done0 + 1;
        if (done1) n_done1 <= n_done1 + 1;
        if (done0 && done1) both_viol <= both_viol + 1;
        if (busy_prev && !spi_busy) fall_cyc <= cyc;
        busy_prev <= spi_busy;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, fails=%0d", fails);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req0  = 1'b0;
        req1  = 1'b0;
        mode  = 0;
        repeat (2) tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic wait_done(input string name, input bit which, input int bound,
                             output int at, output bit ok);
        ok = 1'b0;
        at = -1;
        for (int i = 0; i < bound; i++) begin
            if ((which == 1'b0 && done0) || (which == 1'b1 && done1)) begin
                ok = 1'b1;
                at = cyc;
                break;
            end
            tick();
        end
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL %s: done%0d got none within %0d cycles, required one", name, which, bound);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tests++;
        if ({spi_start, done0, done1, err0, err1, owner, active} !== 7'b0) begin
            fails++;
            $display("FAIL reset_ctrl: got %b required 0000000",
                     {spi_start, done0, done1, err0, err1, owner, active});
        end
        tests++;
        if (spi_data !== 16'h0000 || spi_div !== 16'h0001) begin
            fails++;
            $display("FAIL reset_spi: got data=%h div=%h required 0000/0001", spi_data, spi_div);
        end
        tests++;
        if (rdata0 !== 16'h0000 || rdata1 !== 16'h0000) begin
            fails++;
            $display("FAIL reset_rdata: got %h/%h required 0000/0000", rdata0, rdata1);
        end
        do_reset();
    endtask

    task automatic test_single();
        int at, rc, s0, d1, b;
        bit ok;
        do_reset();
        s0 = n_start; d1 = n_done1; b = start_log.size();
        wdata0 = 16'hA55A; div0 = 16'd2; req0 = 1'b1; rc = cyc;
        tick();
        tests++;
        if (active !== 1'b1 || owner !== 1'b0) begin
            fails++;
            $display("FAIL single_grant: got active=%b owner=%b required 1/0", active, owner);
        end
        wait_done("single_done", 1'b0, 200, at, ok);
        req0 = 1'b0;
        tests++;
        if (err0 !== 1'b0 || rdata0 !== 16'hA55A) begin
            fails++;
            $display("FAIL single_data: got err=%b rdata=%h required 0/a55a", err0, rdata0);
        end
        tests++;
        if (at - fall_cyc != 1) begin
            fails++;
            $display("FAIL single_fall_to_done: got %0d cycles required 1", at - fall_cyc);
        end
        tests++;
        if (start_log.size() <= b || start_log[b] - rc != 2) begin
            fails++;
            $display("FAIL single_req_to_start: got %0d cycles required 2",
                     (start_log.size() > b) ? start_log[b] - rc : -1);
        end
        repeat (12) tick();
        tests++;
        if (n_start - s0 != 1 || n_done1 != d1) begin
            fails++;
            $display("FAIL single_counts: got starts=%0d done1=%0d required 1/0", n_start - s0, n_done1 - d1);
        end
    endtask

    task automatic test_both();
        int t0, t1, b;
        bit ok;
        do_reset();
        b = start_log.size();
        wdata0 = 16'h1111; wdata1 = 16'h2222; div0 = 16'd1; div1 = 16'd1;
        req0 = 1'b1; req1 = 1'b1;
        wait_done("both_done0", 1'b0, 100, t0, ok);
        req0 = 1'b0;
        tests++;
        if (rdata0 !== 16'h1111) begin
            fails++;
            $display("FAIL both_rdata0: got %h required 1111", rdata0);
        end
        wait_done("both_done1", 1'b1, 100, t1, ok);
        req1 = 1'b0;
        tests++;
        if (rdata1 !== 16'h2222 || err1 !== 1'b0) begin
            fails++;
            $display("FAIL both_rdata1: got rdata=%h err=%b required 2222/0", rdata1, err1);
        end
        tests++;
        if (own_log.size() < b + 2 || own_log[b] !== 1'b0 || own_log[b+1] !== 1'b1) begin
            fails++;
            $display("FAIL both_order: got %0d starts, first owners %b%b required 0 then 1",
                     own_log.size() - b, own_log[b], own_log[b+1]);
        end
        tests++;
        if (start_log.size() < b + 2 || start_log[b+1] - t0 != GUARD + 3) begin
            fails++;
            $display("FAIL both_gap: got %0d cycles done0-to-start required %0d",
                     (start_log.size() >= b + 2) ? start_log[b+1] - t0 : -1, GUARD + 3);
        end
    endtask

    task automatic test_alternate();
        int k, b;
        logic [3:0] seq;
        do_reset();
        b = start_log.size();
        k = 0;
        wdata0 = 16'h0F0F; wdata1 = 16'hF0F0; div0 = 16'd1; div1 = 16'd1;
        req0 = 1'b1; req1 = 1'b1;
        for (int i = 0; i < 400 && k < 4; i++) begin
            tick();
            if (done0 || done1) k++;
        end
        req0 = 1'b0; req1 = 1'b0;
        repeat (12) tick();
        tests++;
        if (k != 4 || start_log.size() - b != 4) begin
            fails++;
            $display("FAIL alt_count: got dones=%0d starts=%0d required 4/4", k, start_log.size() - b);
        end
        seq = {own_log[b], own_log[b+1], own_log[b+2], own_log[b+3]};
        tests++;
        if (seq !== 4'b0101) begin
            fails++;
            $display("FAIL alt_order: got %b required 0101", seq);
        end
        tests++;
        if (rdata0 !== 16'h0F0F || rdata1 !== 16'hF0F0) begin
            fails++;
            $display("FAIL alt_rdata: got %h/%h required 0f0f/f0f0", rdata0, rdata1);
        end
    endtask

    task automatic test_div0();
        int at, b;
        bit ok;
        do_reset();
        b = div_log.size();
        wdata1 = 16'h3C3C; div1 = 16'd0; req1 = 1'b1;
        wait_done("div0_done", 1'b1, 100, at, ok);
        req1 = 1'b0;
        tests++;
        if (div_log.size() <= b || div_log[b] !== 16'd1) begin
            fails++;
            $display("FAIL div0_spi_div: got %h required 0001", div_log[b]);
        end
        tests++;
        if (err1 !== 1'b0 || rdata1 !== 16'h3C3C) begin
            fails++;
            $display("FAIL div0_data: got err=%b rdata=%h required 0/3c3c", err1, rdata1);
        end
    endtask

    task automatic test_no_busy();
        int at, b;
        bit ok;
        do_reset();
        wdata0 = 16'h1234; div0 = 16'd1; req0 = 1'b1;
        wait_done("nobusy_pre", 1'b0, 100, at, ok);
        req0 = 1'b0;
        repeat (10) tick();
        mode = 1;
        b = start_log.size();
        wdata0 = 16'h5678; req0 = 1'b1;
        wait_done("nobusy_done", 1'b0, 100, at, ok);
        req0 = 1'b0;
        tests++;
        if (err0 !== 1'b1 || rdata0 !== 16'h1234) begin
            fails++;
            $display("FAIL nobusy_err: got err=%b rdata=%h required 1/1234", err0, rdata0);
        end
        tests++;
        if (start_log.size() <= b || at - start_log[b] != SW) begin
            fails++;
            $display("FAIL nobusy_time: got %0d cycles start-to-done required %0d",
                     (start_log.size() > b) ? at - start_log[b] : -1, SW);
        end
        mode = 0;
        wdata1 = 16'h0ACE; div1 = 16'd1; req1 = 1'b1;
        wait_done("nobusy_next", 1'b1, 100, at, ok);
        req1 = 1'b0;
        tests++;
        if (err1 !== 1'b0 || rdata1 !== 16'h0ACE) begin
            fails++;
            $display("FAIL nobusy_next_data: got err=%b rdata=%h required 0/0ace", err1, rdata1);
        end
    endtask

    task automatic test_busy_timeout();
        int at, at1, b, d;
        bit ok;
        do_reset();
        wdata0 = 16'h7777; div0 = 16'd1; req0 = 1'b1;
        wait_done("to_pre", 1'b0, 100, at, ok);
        req0 = 1'b0;
        repeat (10) tick();
        mode = 2;
        b = start_log.size();
        wdata0 = 16'h9999; req0 = 1'b1;
        wait_done("to_done", 1'b0, 200, at, ok);
        req0 = 1'b0;
        mode = 0;
        tests++;
        if (err0 !== 1'b1 || rdata0 !== 16'h7777 || spi_busy !== 1'b1) begin
            fails++;
            $display("FAIL to_err: got err=%b rdata=%h busy=%b required 1/7777/1", err0, rdata0, spi_busy);
        end
        d = (start_log.size() > b) ? at - start_log[b] : -1;
        tests++;
        if (d < int'(TO) || d > int'(TO) + 4) begin
            fails++;
            $display("FAIL to_time: got %0d cycles start-to-done required %0d..%0d", d, TO, int'(TO) + 4);
        end
        wdata1 = 16'h5A5A; div1 = 16'd1; req1 = 1'b1;
        wait_done("to_next", 1'b1, 300, at1, ok);
        req1 = 1'b0;
        tests++;
        if (err1 !== 1'b0 || rdata1 !== 16'h5A5A) begin
            fails++;
            $display("FAIL to_next_data: got err=%b rdata=%h required 0/5a5a", err1, rdata1);
        end
        d = (start_log.size() > b + 1) ? start_log[b+1] - at : -1;
        tests++;
        if (d <= 120 - int'(TO)) begin
            fails++;
            $display("FAIL to_recover: got next start %0d cycles after done required more than %0d",
                     d, 120 - int'(TO));
        end
    endtask

    task automatic test_reset_mid();
        int at, d0;
        bit ok;
        do_reset();
        d0 = n_done0;
        wdata0 = 16'hBEEF; div0 = 16'd8; req0 = 1'b1;
        for (int i = 0; i < 20 && !spi_busy; i++) tick();
        repeat (3) tick();
        reset = 1'b1;
        #1;
        tests++;
        if ({active, owner, spi_start, done0, done1} !== 5'b0 || spi_data !== 16'h0000 ||
            spi_div !== 16'h0001 || rdata0 !== 16'h0000) begin
            fails++;
            $display("FAIL mid_reset_vals: got act=%b own=%b start=%b data=%h div=%h rdata0=%h required 0/0/0/0000/0001/0000",
                     active, owner, spi_start, spi_data, spi_div, rdata0);
        end
        tick();
        req0 = 1'b0;
        tick();
        reset = 1'b0;
        repeat (40) tick();
        tests++;
        if (n_done0 != d0) begin
            fails++;
            $display("FAIL mid_no_done: got %0d done0 pulses required 0", n_done0 - d0);
        end
        wdata1 = 16'h4242; div1 = 16'd1; req1 = 1'b1;
        wait_done("mid_next", 1'b1, 100, at, ok);
        req1 = 1'b0;
        tests++;
        if (err1 !== 1'b0 || rdata1 !== 16'h4242) begin
            fails++;
            $display("FAIL mid_next_data: got err=%b rdata=%h required 0/4242", err1, rdata1);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_both();
        test_alternate();
        test_div0();
        test_no_busy();
        test_busy_timeout();
        test_reset_mid();
        repeat (5) tick();
        tests++;
        if (both_viol != 0 || busy_start_viol != 0) begin
            fails++;
            $display("FAIL protocol: got both_done=%0d start_while_busy=%0d required 0/0",
                     both_viol, busy_start_viol);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
